tail_light: RTL and testbench
=============================

Name: tail_light

Overview:
- Sequential tail-light controller for a three-lamp-per-side indicator cluster.
- Sequences the left lamps, the right lamps, or both sides (hazard) from three driver request inputs.
- Sits between the driver switch inputs and the lamp drivers.
- Moore FSM; outputs decode directly from the state register.

Parameters:
- TICK_DIV, default 1: clock cycles per FSM step. A value of 1 steps every clock; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-low reset (0 = reset).
- l  input  1  left-turn request.
- r  input  1  right-turn request.
- HAZARD  input  1  hazard request.
- LEFT_INDICATOR  output  3  left lamps. Bit0 = innermost (LA), bit2 = outermost (LC).
- RIGHT_INDICATOR  output  3  right lamps. Bit0 = innermost (RA), bit2 = outermost (RC).

Behaviour:
- Single clock domain.
- Reset: when rst==0 at a rising clk edge:
  - state := IDLE
  - tick counter := 0
  - both indicators read 3'b000 from the next cycle onward.
  - Reset overrides all other inputs.
- Step tick: a modulo-TICK_DIV counter. The tick is asserted on the cycle the counter is 0. With TICK_DIV=1 the tick is asserted every cycle.
- The state changes only on tick cycles. Inputs are sampled at the tick edge.
- Latency: outputs reflect the new state one clk edge after the sampling edge. Outputs are registered and glitch-free.
- States and output decode (LEFT, RIGHT):
  - IDLE: 000, 000
  - L1: 001, 000
  - L2: 011, 000
  - L3: 111, 000
  - R1: 000, 001
  - R2: 000, 011
  - R3: 000, 111
  - LR3: 111, 111
- Request decode, in priority order:
  - haz = HAZARD | (l & r)
  - left = l & ~r & ~HAZARD
  - right = r & ~l & ~HAZARD
- Next state, evaluated from any current state:
  - haz: LR3 → IDLE; any other state → LR3. This gives an all-on/all-off blink, and hazard preempts a sequence immediately.
  - left: L1 → L2, L2 → L3, L3 → IDLE, any other state → L1. Period is 4 steps: 001, 011, 111, 000.
  - right: R1 → R2, R2 → R3, R3 → IDLE, any other state → R1.
  - No request: → IDLE.
- Boundary conditions:
  - Dropping a request mid-sequence returns to IDLE on the next tick.
  - Switching directly from left to right mid-sequence enters R1 on the next tick, with no intermediate IDLE.
  - When hazard is released, the FSM goes to the state that the active request selects.
- Unused encodings (if any are reachable) recover to IDLE on the next tick.

Optional Feature:
- Macro TAIL_LIGHT_STATE_OUT_EN.
- When defined: adds output port dbg_state, 3 bits, carrying the current state encoding (values from the package) for debug and visibility.
- When not defined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package tail_light_pkg:
  - state enum (3 bits): IDLE, L1, L2, L3, R1, R2, R3, LR3.
  - lamp pattern constants: LAMP_OFF=000, LAMP_1=001, LAMP_2=011, LAMP_3=111.
- Sub-module tail_light_tick: parameterised TICK_DIV prescaler. It takes the same clk and rst and produces a one-cycle tick pulse.
- FSM and output decode stay in tail_light.

Test Plan:
- Reset hold: rst=0 for 5 cycles with l=1 → both indicators 000 throughout. After release, the first edge gives LEFT=001.
- Left sequence, TICK_DIV=1: rst=1, l=1, r=0, HAZARD=0 for 8 cycles → LEFT repeats 001, 011, 111, 000 twice; RIGHT stays 000.
- Hazard preempt: during left at L2, set HAZARD=1 → next cycle both indicators 111, then both alternate between 000 and 111.
- l&r as hazard: l=1, r=1, HAZARD=0 → same blink as hazard. Drop to r=1 only while in LR3 → RIGHT=001, LEFT=000 on the next cycle.
- Request drop and direction switch:
  - r=1 to R3 (RIGHT=111), then all inputs 0 → IDLE (000, 000).
  - r=1 to R2, then l=1, r=0 → LEFT=001, RIGHT=000.
- Prescale: TICK_DIV=4, l=1 → LEFT holds each pattern for 4 cycles (001 ×4, 011 ×4, ...). Reset mid-count restarts the counter.

Source files
------------

// File: rtl/tail_light_pkg.sv
// tail_light_pkg
//   Shared types and constants for the tail-light controller.
//   - state_t       : 3-bit FSM state encoding (all eight codes used)
//   - LAMP_*        : three-lamp bar patterns, bit0 = innermost lamp
//   - left_lamps()  : state -> left bar pattern
//   - right_lamps() : state -> right bar pattern
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  function automatic logic [2:0] left_lamps(input state_t s);
    case (s)
      L1:      return LAMP_1;
      L2:      return LAMP_2;
      L3, LR3: return LAMP_3;
      default: return LAMP_OFF;
    endcase
  endfunction

  function automatic logic [2:0] right_lamps(input state_t s);
    case (s)
      R1:      return LAMP_1;
      R2:      return LAMP_2;
      R3, LR3: return LAMP_3;
      default: return LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_tick.sv
// tail_light_tick
//   Step prescaler: asserts tick for one cycle every TICK_DIV clocks.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-low reset (counter cleared to 0)
//     tick : high while the counter is at its terminal count (0)
//   Parameter TICK_DIV: clocks per step, 1..65535 (1 = tick every cycle).
module tail_light_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(TICK_DIV - 1);

  logic [15:0] count;

  // Down-counter: reset to 0 so the very first edge after reset is a tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/tail_light.sv
// tail_light
//   Sequential tail-light controller: left sweep, right sweep, or hazard
//   blink across two three-lamp bars. Moore FSM stepped by a prescaled tick;
//   lamp outputs are registered from the next-state decode so they change
//   on the same edge as the state register and never glitch.
//   Ports:
//     clk             : system clock, rising edge
//     rst             : synchronous active-low reset
//     l, r, HAZARD    : left / right / hazard requests
//     dbg_state       : current state code (only with TAIL_LIGHT_STATE_OUT_EN)
//     LEFT_INDICATOR  : left lamps, bit0 = LA (inner) .. bit2 = LC (outer)
//     RIGHT_INDICATOR : right lamps, bit0 = RA (inner) .. bit2 = RC (outer)
//   Optional macro: TAIL_LIGHT_STATE_OUT_EN adds the dbg_state output.
//
//   state | meaning
//   IDLE  | all lamps off
//   L1    | left 001
//   L2    | left 011
//   L3    | left 111
//   R1    | right 001
//   R2    | right 011
//   R3    | right 111
//   LR3   | hazard, both bars 111
module tail_light
  import tail_light_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l,
  input  logic       r,
  input  logic       HAZARD,
`ifdef TAIL_LIGHT_STATE_OUT_EN
  output logic [2:0] dbg_state,
`endif
  output logic [2:0] LEFT_INDICATOR,
  output logic [2:0] RIGHT_INDICATOR
);

  state_t state;
  state_t next_state;
  logic   tick;
  logic   haz;
  logic   left;
  logic   right;

  tail_light_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // l & r together is treated as a hazard request.
  assign haz   = HAZARD | (l & r);
  assign left  = l & ~r & ~HAZARD;
  assign right = r & ~l & ~HAZARD;

  always_comb begin
    next_state = state;
    if (tick) begin
      if (haz) begin
        next_state = (state == LR3) ? IDLE : LR3;
      end else if (left) begin
        case (state)
          L1:      next_state = L2;
          L2:      next_state = L3;
          L3:      next_state = IDLE;
          default: next_state = L1;
        endcase
      end else if (right) begin
        case (state)
          R1:      next_state = R2;
          R2:      next_state = R3;
          R3:      next_state = IDLE;
          default: next_state = R1;
        endcase
      end else begin
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      LEFT_INDICATOR  <= LAMP_OFF;
      RIGHT_INDICATOR <= LAMP_OFF;
    end else begin
      state           <= next_state;
      LEFT_INDICATOR  <= left_lamps(next_state);
      RIGHT_INDICATOR <= right_lamps(next_state);
    end
  end

`ifdef TAIL_LIGHT_STATE_OUT_EN
  assign dbg_state = state;
`endif

endmodule

// File: tb/tb_tail_light.sv
module tb_tail_light;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst4;
  logic       l;
  logic       r;
  logic       hazard;
  logic [2:0] left1;
  logic [2:0] right1;
  logic [2:0] left4;
  logic [2:0] right4;
`ifdef TAIL_LIGHT_STATE_OUT_EN
  logic [2:0] dbg1;
  logic [2:0] dbg4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tail_light #(.TICK_DIV(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .l              (l),
    .r              (r),
    .HAZARD         (hazard),
`ifdef TAIL_LIGHT_STATE_OUT_EN
    .dbg_state      (dbg1),
`endif
    .LEFT_INDICATOR (left1),
    .RIGHT_INDICATOR(right1)
  );

  tail_light #(.TICK_DIV(4)) dut4 (
    .clk            (clk),
    .rst            (rst4),
    .l              (l),
    .r              (r),
    .HAZARD         (hazard),
`ifdef TAIL_LIGHT_STATE_OUT_EN
    .dbg_state      (dbg4),
`endif
    .LEFT_INDICATOR (left4),
    .RIGHT_INDICATOR(right4)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge on the TICK_DIV=1 instance, then check both bars.
  task automatic step1(input string tag, input logic [2:0] el, input logic [2:0] er);
    @(posedge clk);
    #1;
    chk({tag, "_left"}, left1, el);
    chk({tag, "_right"}, right1, er);
  endtask

  task automatic step4(input string tag, input logic [2:0] el, input logic [2:0] er);
    @(posedge clk);
    #1;
    chk({tag, "_left4"}, left4, el);
    chk({tag, "_right4"}, right4, er);
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    l = 1'b1; r = 1'b0; hazard = 1'b0;

    // Reset hold with l asserted
    for (int i = 0; i < 5; i++) step1("reset_hold", 3'b000, 3'b000);

    // Left sequence, two full periods
    rst = 1'b1;
    step1("left_a1", 3'b001, 3'b000);
    step1("left_a2", 3'b011, 3'b000);
    step1("left_a3", 3'b111, 3'b000);
    step1("left_a0", 3'b000, 3'b000);
    step1("left_b1", 3'b001, 3'b000);
    step1("left_b2", 3'b011, 3'b000);
    step1("left_b3", 3'b111, 3'b000);
    step1("left_b0", 3'b000, 3'b000);

    // Hazard preempts left at L2
    step1("pre_l1", 3'b001, 3'b000);
    step1("pre_l2", 3'b011, 3'b000);
    hazard = 1'b1;
    step1("haz_on1", 3'b111, 3'b111);
    step1("haz_off1", 3'b000, 3'b000);
    step1("haz_on2", 3'b111, 3'b111);
    step1("haz_off2", 3'b000, 3'b000);

    // l & r behaves as hazard; drop to r only while in LR3
    hazard = 1'b0; l = 1'b1; r = 1'b1;
    step1("lr_on1", 3'b111, 3'b111);
    step1("lr_off1", 3'b000, 3'b000);
    step1("lr_on2", 3'b111, 3'b111);
    l = 1'b0;
    step1("lr_to_r1", 3'b000, 3'b001);
    step1("right_r2", 3'b000, 3'b011);
    step1("right_r3", 3'b000, 3'b111);

    // Drop all requests at R3
    r = 1'b0;
    step1("drop_idle", 3'b000, 3'b000);

    // Right to R2, then switch straight to left
    r = 1'b1;
    step1("sw_r1", 3'b000, 3'b001);
    step1("sw_r2", 3'b000, 3'b011);
    l = 1'b1; r = 1'b0;
    step1("sw_l1", 3'b001, 3'b000);

    // Hazard released with left active
    hazard = 1'b1;
    step1("rel_haz", 3'b111, 3'b111);
    hazard = 1'b0;
    step1("rel_l1", 3'b001, 3'b000);

    // Drop to idle while the TICK_DIV=4 instance is brought out of reset
    l = 1'b0;
    step4("p_reset", 3'b000, 3'b000);
    rst4 = 1'b1; l = 1'b1;
    for (int i = 0; i < 4; i++) step4("p_l1", 3'b001, 3'b000);
    for (int i = 0; i < 4; i++) step4("p_l2", 3'b011, 3'b000);
    for (int i = 0; i < 4; i++) step4("p_l3", 3'b111, 3'b000);
    for (int i = 0; i < 2; i++) step4("p_l0", 3'b000, 3'b000);

    // Reset mid-count restarts the prescaler: next edge is a tick
    rst4 = 1'b0;
    step4("p_midrst", 3'b000, 3'b000);
    rst4 = 1'b1;
    for (int i = 0; i < 4; i++) step4("p_rs_l1", 3'b001, 3'b000);
    step4("p_rs_l2", 3'b011, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
